// File: rtl/dual_stage_shift_reg_pkg.sv
// Shared definitions for the dual_stage_shift_reg delay line.
//
// Contents:
//   DEPTH_DEFAULT  default number of register stages between d and dout
//   WIDTH_DEFAULT  default bit width of the data path
//   DEPTH_MIN/MAX  legal range for the DEPTH parameter
//   data_t         data word at the default width
//   depth_is_legal helper that reports whether a DEPTH value is in range
package dual_stage_shift_reg_pkg;

    localparam int DEPTH_DEFAULT = 2;
    localparam int WIDTH_DEFAULT = 1;
    localparam int DEPTH_MIN     = 1;
    localparam int DEPTH_MAX     = 64;

    typedef logic [WIDTH_DEFAULT-1:0] data_t;

    function automatic bit depth_is_legal(input int depth);
        return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
    endfunction

endpackage

// File: rtl/dual_stage_shift_reg_stage.sv
// shift_stage: one WIDTH-bit D flip-flop with synchronous active-low clear.
// It is the building block chained by dual_stage_shift_reg.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low clear (stage goes to 0 when sampled low)
//   d      data captured on the rising edge
//   q      registered output
module shift_stage
    import dual_stage_shift_reg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dual_stage_shift_reg.sv
// dual_stage_shift_reg: serial-in/serial-out delay line of DEPTH registers.
// A word sampled on d at edge N is visible on dout just after edge
// N+DEPTH-1. Reset is synchronous and active-low and flushes every stage.
//
// Parameters:
//   DEPTH  number of register stages (1..64)
//   WIDTH  bit width of d, every stage and dout
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low clear of the whole chain
//   d      data input
//   dout   data output, taken straight from the last stage register
module dual_stage_shift_reg
    import dual_stage_shift_reg_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] dout
);

    // Output of each stage; stage[DEPTH-1] is the tail of the chain.
    logic [WIDTH-1:0] stage [DEPTH];

    // Each stage is a separate flop instance so synthesis cannot merge
    // stages; stage i always loads the pre-edge value of stage i-1.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            shift_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .d     (d),
                .q     (stage[0])
            );
        end else begin : g_body
            shift_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .d     (stage[i-1]),
                .q     (stage[i])
            );
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: tb/tb_dual_stage_shift_reg.sv
// Self-checking bench for dual_stage_shift_reg.
// Four instances share clk/reset: DEPTH=2/WIDTH=1 (main) and DEPTH=1,3,8
// with WIDTH=4. A queue per instance holds the values dout must show on
// successive edges; entries are pushed as d is sampled and popped as the
// corresponding edge completes.
module tb_dual_stage_shift_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       d1;
    logic [3:0] d4;
    logic       dout2;
    logic [3:0] dout_a;
    logic [3:0] dout_b;
    logic [3:0] dout_c;

    int tests = 0;
    int fails = 0;
    int edge_no = 0;
    bit primed = 1'b0;

    logic       q2 [$];
    logic [3:0] qa [$];
    logic [3:0] qb [$];
    logic [3:0] qc [$];
    logic       e2;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [3:0] ec;

    always #20 clk = ~clk;

    dual_stage_shift_reg #(.DEPTH(2), .WIDTH(1)) u_dut2 (
        .clk (clk), .reset (reset), .d (d1), .dout (dout2)
    );
    dual_stage_shift_reg #(.DEPTH(1), .WIDTH(4)) u_dut1 (
        .clk (clk), .reset (reset), .d (d4), .dout (dout_a)
    );
    dual_stage_shift_reg #(.DEPTH(3), .WIDTH(4)) u_dut3 (
        .clk (clk), .reset (reset), .d (d4), .dout (dout_b)
    );
    dual_stage_shift_reg #(.DEPTH(8), .WIDTH(4)) u_dut8 (
        .clk (clk), .reset (reset), .d (d4), .dout (dout_c)
    );

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s edge %0d: observed %h expected %h", tag, edge_no, observed, expected);
        end
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Model update from the values present at the rising edge.
    task automatic update_model();
        if (reset === 1'b0) begin
            q2.delete();
            q2.push_back(1'b0);
            qa.delete();
            qb.delete();
            repeat (2) qb.push_back(4'h0);
            qc.delete();
            repeat (7) qc.push_back(4'h0);
            e2 = 1'b0;
            ea = 4'h0;
            eb = 4'h0;
            ec = 4'h0;
            primed = 1'b1;
        end else if (primed) begin
            q2.push_back(d1);
            e2 = q2.pop_front();
            qa.push_back(d4);
            ea = qa.pop_front();
            qb.push_back(d4);
            eb = qb.pop_front();
            qc.push_back(d4);
            ec = qc.pop_front();
        end
    endtask

    task automatic check_output();
        if (primed) begin
            check("dout_depth2", {3'b000, dout2}, {3'b000, e2});
            check("dout_depth1", dout_a, ea);
            check("dout_depth3", dout_b, eb);
            check("dout_depth8", dout_c, ec);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_no++;
        update_model();
        #1;
        check_output();
    endtask

    task automatic apply_stimulus(input logic r, input logic dv, input logic [3:0] dw);
        reset = r;
        d1    = dv;
        d4    = dw;
        step();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        int n;
        int pos1;
        int pos3;
        int pos8;

        // Slow toggle: d flips every 223 ns, reset low until 113 ns.
        reset = 1'b0;
        d1    = 1'b0;
        d4    = 4'h0;
        fork
            begin
                #113 reset = 1'b1;
            end
            begin
                repeat (8) begin
                    #223 d1 = ~d1;
                end
            end
            begin
                repeat (50) step();
            end
        join

        // Reset hold: d is ignored, dout stays 0.
        repeat (3) begin
            apply_stimulus(1'b0, 1'b1, 4'hF);
            check("reset_hold", {3'b000, dout2}, 4'h0);
        end

        // Latency for DEPTH=2: one-cycle pulse.
        apply_stimulus(1'b1, 1'b1, 4'h0);
        check("latency_capture", {3'b000, dout2}, 4'h0);
        apply_stimulus(1'b1, 1'b0, 4'h0);
        check("latency_visible", {3'b000, dout2}, 4'h1);
        apply_stimulus(1'b1, 1'b0, 4'h0);
        check("latency_gone", {3'b000, dout2}, 4'h0);

        // Alternating pattern must come out delayed by two edges.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, (i % 2) == 0, 4'h0);
        end

        // Mid-stream reset.
        n = 0;
        do begin
            apply_stimulus(1'b1, 1'b1, 4'h0);
            n++;
        end while (dout2 !== 1'b1 && n < 10);
        check("stream_reach_one", {3'b000, dout2}, 4'h1);
        apply_stimulus(1'b0, 1'b1, 4'h0);
        check("midreset_flush", {3'b000, dout2}, 4'h0);
        apply_stimulus(1'b1, 1'b1, 4'h0);
        check("release_zero", {3'b000, dout2}, 4'h0);
        apply_stimulus(1'b1, 1'b1, 4'h0);
        check("resume_one", {3'b000, dout2}, 4'h1);

        // Parameter sweep: single 4'hA pulse through DEPTH=1,3,8.
        apply_stimulus(1'b0, 1'b0, 4'h0);
        pos1 = -1;
        pos3 = -1;
        pos8 = -1;
        for (int k = 1; k <= 11; k++) begin
            apply_stimulus(1'b1, 1'b0, (k == 1) ? 4'hA : 4'h0);
            if (dout_a === 4'hA && pos1 < 0) pos1 = k;
            if (dout_b === 4'hA && pos3 < 0) pos3 = k;
            if (dout_c === 4'hA && pos8 < 0) pos8 = k;
        end
        check_int("sweep_pos_depth1", pos1, 1);
        check_int("sweep_pos_depth3", pos3, 3);
        check_int("sweep_pos_depth8", pos8, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
